// File: rtl/tdc_measure_ctrl.sv
// rtl/tdc_measure_ctrl.sv - TDC batch measurement controller with averaging
//
// Purpose:
//   Measures start-to-stop intervals in clk cycles. After an arm request it
//   collects N = 2^avg_sel samples and accumulates them. It then presents
//   their truncated average on a valid/ready result port. A sample that sees
//   no stop edge saturates at 16'hFFFF and sets a sticky timeout flag.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   arm           in   start a batch (accepted only in IDLE)
//   start_evt     in   synchronized start-edge pulse
//   stop_evt      in   synchronized stop-edge pulse
//   avg_sel[1:0]  in   batch size select, N = 1, 2, 4, 8
//   byte_sel[1:0] in   uo_out view select
//   result_ready  in   consumer accepts the result while in DONE
//   result[15:0]  out  averaged interval, held until the next batch completes
//   result_valid  out  high exactly while in DONE
//   busy          out  high in every state except IDLE
//   timeout_flag  out  sticky timeout indication for the current batch
//   uo_out[7:0]   out  byte view of result/status/sample count
module tdc_measure_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        start_evt,
  input  logic        stop_evt,
  input  logic [1:0]  avg_sel,
  input  logic [1:0]  byte_sel,
  input  logic        result_ready,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        timeout_flag,
  output logic [7:0]  uo_out
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    COUNT      = 3'd2,
    ACCUM      = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] cnt;
  logic [15:0] sample;
  logic [18:0] acc;
  logic [3:0]  sample_count;
  logic [1:0]  avg_lat;

  logic [15:0] cnt_inc;
  logic        cnt_sat;
  logic [3:0]  batch_n;
  logic        batch_last;
  logic [18:0] acc_sum;
  logic [15:0] avg_val;

  // cnt is zero on the start edge, so cnt + 1 is the interval length that
  // would be reported if stop arrived on the current edge.
  assign cnt_inc    = cnt + 16'd1;
  assign cnt_sat    = (cnt_inc == 16'hFFFF);
  assign batch_n    = 4'd1 << avg_lat;
  assign batch_last = ((sample_count + 4'd1) == batch_n);
  assign acc_sum    = acc + {3'b000, sample};

  // Truncating divide by 2^avg_lat; the largest possible sum (8 * 16'hFFFF)
  // shifted by 3 always fits in 16 bits.
  always_comb begin
    avg_val = acc_sum[15:0];
    case (avg_lat)
      2'd0: avg_val = acc_sum[15:0];
      2'd1: avg_val = acc_sum[16:1];
      2'd2: avg_val = acc_sum[17:2];
      2'd3: avg_val = acc_sum[18:3];
      default: avg_val = acc_sum[15:0];
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt = WAIT_START;
        end
      end
      WAIT_START: begin
        // stop_evt here (including one coincident with start_evt) is ignored
        if (start_evt) begin
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (stop_evt || cnt_sat) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        state_nxt = batch_last ? DONE : WAIT_START;
      end
      DONE: begin
        if (result_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= 16'd0;
      sample       <= 16'd0;
      acc          <= 19'd0;
      sample_count <= 4'd0;
      avg_lat      <= 2'd0;
      result       <= 16'd0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            avg_lat      <= avg_sel;
            acc          <= 19'd0;
            sample_count <= 4'd0;
            timeout_flag <= 1'b0;
          end
        end
        WAIT_START: begin
          if (start_evt) begin
            cnt <= 16'd0;
          end
        end
        COUNT: begin
          cnt <= cnt_inc;
          // On saturation cnt_inc is already 16'hFFFF, so one load covers both exits
          if (stop_evt || cnt_sat) begin
            sample <= cnt_inc;
          end
          if (!stop_evt && cnt_sat) begin
            timeout_flag <= 1'b1;
          end
        end
        ACCUM: begin
          acc          <= acc_sum;
          sample_count <= sample_count + 4'd1;
          if (batch_last) begin
            result <= avg_val;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);

  always_comb begin
    uo_out = 8'h00;
    case (byte_sel)
      2'd0: uo_out = result[7:0];
      2'd1: uo_out = result[15:8];
      2'd2: uo_out = {busy, result_valid, timeout_flag, state, 2'b00};
      2'd3: uo_out = {4'b0000, sample_count};
      default: uo_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// tb/tb_tdc_measure_ctrl.sv - scoreboard testbench for tdc_measure_ctrl
module tb_tdc_measure_ctrl;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        start_evt;
  logic        stop_evt;
  logic [1:0]  avg_sel;
  logic [1:0]  byte_sel;
  logic        result_ready;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        timeout_flag;
  logic [7:0]  uo_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        tf;
  } exp_t;

  exp_t exp_q[$];

  tdc_measure_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .start_evt    (start_evt),
    .stop_evt     (stop_evt),
    .avg_sel      (avg_sel),
    .byte_sel     (byte_sel),
    .result_ready (result_ready),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .timeout_flag (timeout_flag),
    .uo_out       (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted result is popped from the scoreboard and compared
  always @(negedge clk) begin
    exp_t e;
    if (!rst && result_valid && result_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got=%h expected=none", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e.res) begin
          errors++;
          $display("FAIL result got=%h expected=%h", result, e.res);
        end
        checks++;
        if (timeout_flag !== e.tf) begin
          errors++;
          $display("FAIL result_timeout got=%b expected=%b", timeout_flag, e.tf);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string name, input logic [1:0] sel, input logic [7:0] want);
    byte_sel = sel;
    #1;
    check(name, {8'h00, uo_out}, {8'h00, want});
    byte_sel = 2'd0;
  endtask

  // One sample of k cycles (k >= 2); optionally pulses arm mid-count
  task automatic measure(input int k, input bit arm_mid);
    start_evt = 1'b1;
    step();
    start_evt = 1'b0;
    for (int i = 0; i < k - 1; i++) begin
      arm = (arm_mid && i == 0);
      step();
    end
    arm = 1'b0;
    stop_evt = 1'b1;
    step();
    stop_evt = 1'b0;
    step();
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!result_valid && n < bound) begin
      step();
      n++;
    end
    check("wait_valid", {15'd0, result_valid}, 16'd1);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    start_evt = 1'b0;
    stop_evt = 1'b0;
    avg_sel = 2'd0;
    byte_sel = 2'd0;
    result_ready = 1'b0;

    // Reset state
    #12;
    check("rst_result", result, 16'd0);
    check("rst_valid", {15'd0, result_valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_timeout", {15'd0, timeout_flag}, 16'd0);
    peek("rst_status", 2'd2, 8'h00);
    rst = 1'b0;
    step();

    // Single sample of 37 cycles, coincident start/stop ignored, latency
    exp_q.push_back('{res: 16'd37, tf: 1'b0});
    avg_sel = 2'd0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    start_evt = 1'b1;
    stop_evt = 1'b1;
    step();
    start_evt = 1'b0;
    stop_evt = 1'b0;
    repeat (36) step();
    stop_evt = 1'b1;
    step();
    stop_evt = 1'b0;
    peek("accum_status", 2'd2, 8'h8C);
    check("accum_valid_low", {15'd0, result_valid}, 16'd0);
    step();
    check("latency_valid", {15'd0, result_valid}, 16'd1);
    peek("res37_lo", 2'd0, 8'd37);
    accept();
    check("idle_after_accept", {15'd0, busy}, 16'd0);
    check("result_held", result, 16'd37);

    // Four-sample batch, ignored stop in WAIT_START and ignored arm pulses
    exp_q.push_back('{res: 16'd11, tf: 1'b0});
    avg_sel = 2'd2;
    arm = 1'b1;
    step();
    arm = 1'b0;
    avg_sel = 2'd0;
    stop_evt = 1'b1;
    step();
    stop_evt = 1'b0;
    peek("stop_in_wait", 2'd2, 8'h84);
    measure(10, 1'b1);
    arm = 1'b1;
    step();
    arm = 1'b0;
    measure(11, 1'b0);
    measure(12, 1'b1);
    measure(14, 1'b0);
    wait_valid(10);
    peek("count_in_done", 2'd3, 8'h04);
    peek("res11_lo", 2'd0, 8'h0B);
    peek("res11_hi", 2'd1, 8'h00);
    arm = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      arm = 1'b0;
      check("hold_valid", {15'd0, result_valid}, 16'd1);
      check("hold_result", result, 16'd11);
    end
    accept();

    // Timeout: no stop edge
    exp_q.push_back('{res: 16'hFFFF, tf: 1'b1});
    avg_sel = 2'd0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    start_evt = 1'b1;
    step();
    start_evt = 1'b0;
    wait_valid(70000);
    peek("timeout_status", 2'd2, 8'hF0);
    check("timeout_flag_done", {15'd0, timeout_flag}, 16'd1);
    accept();
    peek("timeout_sticky_idle", 2'd2, 8'h20);

    // Reset during COUNT aborts the batch; arm then clears the flag
    arm = 1'b1;
    step();
    arm = 1'b0;
    peek("arm_clears_flag", 2'd2, 8'h84);
    start_evt = 1'b1;
    step();
    start_evt = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("midrst_result", result, 16'd0);
    check("midrst_valid", {15'd0, result_valid}, 16'd0);
    check("midrst_busy", {15'd0, busy}, 16'd0);
    check("midrst_count", {12'd0, uo_out[3:0] & 4'h0} | {8'd0, 8'h00}, 16'd0);
    byte_sel = 2'd2;
    #1;
    check("midrst_status", {8'h00, uo_out}, 16'h0000);
    byte_sel = 2'd0;
    rst = 1'b0;
    result_ready = 1'b1;
    repeat (5) step();
    result_ready = 1'b0;
    check("no_valid_after_rst", {15'd0, result_valid}, 16'd0);

    exp_q.push_back('{res: 16'd5, tf: 1'b0});
    arm = 1'b1;
    step();
    arm = 1'b0;
    measure(5, 1'b0);
    wait_valid(10);
    accept();

    step();
    check("scoreboard_empty", exp_q.size()[15:0], 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
